// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - PC register, I-cache fetch port and IF/ID register of the 5-stage core
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   PCWrite, IFIDWrite             hazard unit load-use holds (0 = hold)
//   Flush, BranchTarget            ID-stage redirect and its target address
//   ICACHE_stall, DCACHE_stall     cache misses; either one freezes the fetch stage
//   ICACHE_rdata                   instruction word at ICACHE_addr
//   ICACHE_ren, ICACHE_addr        fetch request and word address (PC[31:2])
//   IFID_PC4, IFID_Inst, IFID_Valid  IF/ID pipeline register
//   CntLoadUse, CntFlush, CntFreeze  saturating event counters
module fetch_stage_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             Flush,
  input  logic [31:0]      BranchTarget,
  input  logic             ICACHE_stall,
  input  logic             DCACHE_stall,
  input  logic [31:0]      ICACHE_rdata,
  output logic             ICACHE_ren,
  output logic [29:0]      ICACHE_addr,
  output logic [31:0]      IFID_PC4,
  output logic [31:0]      IFID_Inst,
  output logic             IFID_Valid,
  output logic [CNT_W-1:0] CntLoadUse,
  output logic [CNT_W-1:0] CntFlush,
  output logic [CNT_W-1:0] CntFreeze
);

  typedef enum logic [1:0] {BOOT, RUN, FREEZE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] ifid_pc4_nxt, ifid_inst_nxt;
  logic        ifid_valid_nxt;
  logic        freeze;
  logic        inc_load_use, inc_flush, inc_freeze;

  assign freeze      = ICACHE_stall | DCACHE_stall;
  assign pc_plus4    = pc + 32'd4;
  assign ICACHE_addr = pc[31:2];
  assign ICACHE_ren  = !rst && (state != BOOT);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ifid_pc4_nxt   = IFID_PC4;
    ifid_inst_nxt  = IFID_Inst;
    ifid_valid_nxt = IFID_Valid;
    inc_load_use   = 1'b0;
    inc_flush      = 1'b0;
    inc_freeze     = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, FREEZE: begin
        // The cycle leaving FREEZE already fetches, so both states share the datapath.
        state_nxt = freeze ? FREEZE : RUN;
        if (freeze) begin
          // Flush is left pending: the frozen ID stage keeps asserting it.
          inc_freeze = 1'b1;
        end else if (!PCWrite) begin
          // Branch operands are not ready during a load-use stall, so Flush waits.
          inc_load_use = 1'b1;
        end else if (Flush) begin
          pc_nxt         = BranchTarget & ~32'h3;
          ifid_pc4_nxt   = pc_plus4;
          ifid_inst_nxt  = 32'h0;
          ifid_valid_nxt = 1'b0;
          inc_flush      = 1'b1;
        end else begin
          pc_nxt = pc_plus4;
          if (IFIDWrite) begin
            ifid_pc4_nxt   = pc_plus4;
            ifid_inst_nxt  = ICACHE_rdata;
            ifid_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= PC_RESET;
      IFID_PC4   <= 32'h0;
      IFID_Inst  <= 32'h0;
      IFID_Valid <= 1'b0;
      CntLoadUse <= '0;
      CntFlush   <= '0;
      CntFreeze  <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      IFID_PC4   <= ifid_pc4_nxt;
      IFID_Inst  <= ifid_inst_nxt;
      IFID_Valid <= ifid_valid_nxt;
      if (inc_load_use && (CntLoadUse != '1)) CntLoadUse <= CntLoadUse + 1'b1;
      if (inc_flush    && (CntFlush   != '1)) CntFlush   <= CntFlush + 1'b1;
      if (inc_freeze   && (CntFreeze  != '1)) CntFreeze  <= CntFreeze + 1'b1;
    end
  end

  // The hazard unit never advances PC while holding IF/ID; doing so would drop an instruction.
  hazard_combo_legal: assert property (@(posedge clk) disable iff (rst)
    ((state != BOOT) && !freeze) |-> !(PCWrite && !IFIDWrite));

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb/tb_fetch_stage_ctrl.sv - randomized self-checking bench for fetch_stage_ctrl
module tb_fetch_stage_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, PCWrite, IFIDWrite, Flush, ICACHE_stall, DCACHE_stall;
  logic [31:0]      BranchTarget, ICACHE_rdata;
  logic             ICACHE_ren;
  logic [29:0]      ICACHE_addr;
  logic [31:0]      IFID_PC4, IFID_Inst;
  logic             IFID_Valid;
  logic [CNT_W-1:0] CntLoadUse, CntFlush, CntFreeze;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the fetch stage should hold after each edge.
  bit          m_boot;
  logic [31:0] m_pc, m_pc4, m_inst;
  bit          m_valid;
  int          m_lu, m_fl, m_fz;

  always #5 clk = ~clk;

  // Memory image: word at byte address a is 0x20080001 + a.
  assign ICACHE_rdata = 32'h2008_0001 + {ICACHE_addr, 2'b00};

  fetch_stage_ctrl #(.PC_RESET(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Flush(Flush),
    .BranchTarget(BranchTarget), .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
    .ICACHE_rdata(ICACHE_rdata), .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr),
    .IFID_PC4(IFID_PC4), .IFID_Inst(IFID_Inst), .IFID_Valid(IFID_Valid),
    .CntLoadUse(CntLoadUse), .CntFlush(CntFlush), .CntFreeze(CntFreeze)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_edge(input bit r, input bit pcw, input bit fl, input logic [31:0] bt,
                            input bit frz);
    if (r) begin
      m_boot = 1; m_pc = 0; m_pc4 = 0; m_inst = 0; m_valid = 0;
      m_lu = 0; m_fl = 0; m_fz = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (frz) begin
      m_fz = sat_inc(m_fz);
    end else if (!pcw) begin
      m_lu = sat_inc(m_lu);
    end else if (fl) begin
      m_pc4 = m_pc + 4; m_inst = 0; m_valid = 0;
      m_pc = {bt[31:2], 2'b00};
      m_fl = sat_inc(m_fl);
    end else begin
      m_pc4 = m_pc + 4; m_inst = 32'h2008_0001 + m_pc; m_valid = 1;
      m_pc = m_pc + 4;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare away from the edge.
  task automatic step(input bit r, input bit hold, input bit fl, input logic [31:0] bt,
                      input bit is, input bit ds);
    rst = r; PCWrite = !hold; IFIDWrite = !hold; Flush = fl; BranchTarget = bt;
    ICACHE_stall = is; DCACHE_stall = ds;
    @(posedge clk);
    model_edge(r, !hold, fl, bt, is | ds);
    #1;
    check("addr",    {2'b00, ICACHE_addr}, {2'b00, m_pc[31:2]});
    check("ren",     {31'd0, ICACHE_ren},  {31'd0, !r && !m_boot});
    check("pc4",     IFID_PC4,             m_pc4);
    check("inst",    IFID_Inst,            m_inst);
    check("valid",   {31'd0, IFID_Valid},  {31'd0, m_valid});
    check("cnt_lu",  {28'd0, CntLoadUse},  m_lu);
    check("cnt_fl",  {28'd0, CntFlush},    m_fl);
    check("cnt_fz",  {28'd0, CntFreeze},   m_fz);
  endtask

  initial begin
    m_boot = 1; m_pc = 0; m_pc4 = 0; m_inst = 0; m_valid = 0; m_lu = 0; m_fl = 0; m_fz = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_ren", {31'd0, ICACHE_ren}, 32'd0);
    step(0, 0, 0, 0, 0, 0);                 // BOOT cycle
    step(0, 0, 0, 0, 0, 0);                 // fetch addr 0
    check("boot_pc4_a", IFID_PC4, 32'd4);
    step(0, 0, 0, 0, 0, 0);                 // fetch addr 1
    check("boot_addr2", {2'b00, ICACHE_addr}, 32'd2);
    step(0, 1, 0, 0, 0, 0);                 // load-use hold at PC 0x8
    check("lu_addr_held", {2'b00, ICACHE_addr}, 32'd2);
    check("lu_cnt", {28'd0, CntLoadUse}, 32'd1);
    step(0, 0, 0, 0, 0, 0);                 // PC 0x8 -> 0xC
    step(0, 0, 1, 32'h40, 0, 0);            // redirect at PC 0xC
    check("fl_addr", {2'b00, ICACHE_addr}, 32'h10);
    check("fl_bubble", IFID_Inst, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    check("fl_pc4", IFID_PC4, 32'h44);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);
    check("ic_freeze_cnt", {28'd0, CntFreeze}, 32'd10);
    step(0, 0, 0, 0, 0, 0);                 // fetch completes after stall drops
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h103, 0, 1);
    check("fz_flush_cnt", {28'd0, CntFlush}, 32'd1);
    step(0, 0, 1, 32'h103, 0, 0);           // redirect applied once, low bits dropped
    check("fz_flush_addr", {2'b00, ICACHE_addr}, 32'h40);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h200, 0, 0);           // load-use beats flush
    check("lu_flush_addr", {2'b00, ICACHE_addr}, 32'h41);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, i[0], !i[0]);
    check("fz_saturate", {28'd0, CntFreeze}, 32'd15);
    step(1, 0, 0, 0, 1, 0);                 // reset mid-freeze
    check("rst_mid_valid", {31'd0, IFID_Valid}, 32'd0);
    check("rst_mid_cnt", {28'd0, CntFreeze}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      bit r, h, f, is, ds;
      r  = ($urandom_range(63) == 0);
      h  = ($urandom_range(5) == 0);
      f  = ($urandom_range(4) == 0);
      is = ($urandom_range(5) == 0);
      ds = ($urandom_range(7) == 0);
      step(r, h, f, $urandom, is, ds);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
